// File: rtl/idex_pipe_reg_pkg.sv
// idex_pipe_reg_pkg: opcodes, encodings and decode helpers shared by the ID/EX
// register and the forwarding unit.
package idex_pipe_reg_pkg;

    localparam int DATA_W = 16;

    localparam logic [4:0] OP_HALT    = 5'b00000;
    localparam logic [4:0] OP_NOP     = 5'b00001;
    localparam logic [4:0] OP_J       = 5'b00100;
    localparam logic [4:0] OP_JAL     = 5'b00110;
    localparam logic [4:0] OP_ST      = 5'b10000;
    localparam logic [4:0] OP_LD      = 5'b10001;
    localparam logic [4:0] OP_SLBI    = 5'b10010;
    localparam logic [4:0] OP_STU     = 5'b10011;
    localparam logic [4:0] OP_LBI     = 5'b11000;
    localparam logic [4:0] OP_SHIFT_R = 5'b11010;
    localparam logic [4:0] OP_ALU_R   = 5'b11011;

    localparam logic [15:0] NOP_ENC = {OP_NOP, 11'b0};

    typedef enum logic [1:0] {
        RD_4_2  = 2'b00,
        RD_7_5  = 2'b01,
        RD_10_8 = 2'b10,
        RD_R7   = 2'b11
    } regdst_e;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BUBBLE,
        ST_HALT
    } state_e;

    // LBI/SLBI write [10:8] regardless of the regdst field they carry
    function automatic logic [2:0] dst_reg(input logic [15:2] instr, input logic [1:0] regdst);
        return (instr[15:11] == OP_LBI || instr[15:11] == OP_SLBI || regdst == RD_10_8) ? instr[10:8] :
               regdst == RD_7_5 ? instr[7:5] :
               regdst == RD_R7  ? 3'd7 : instr[4:2];
    endfunction

    function automatic logic rs_used(input logic [4:0] op);
        return !(op == OP_HALT || op == OP_NOP || op == OP_LBI || op == OP_J || op == OP_JAL);
    endfunction

    function automatic logic rt_used(input logic [4:0] op);
        return op == OP_ALU_R || op == OP_SHIFT_R || op[4:2] == 3'b111 || op == OP_ST || op == OP_STU;
    endfunction

endpackage

// File: rtl/idex_pipe_reg_if.sv
// idex_pipe_reg_if: decode-side inputs and EX-side outputs of the ID/EX register.
interface idex_pipe_reg_if #(
    parameter int W     = 16,
    parameter int CNT_W = 16
);
    logic [W-1:0]     instr_dec;
    logic             valid_dec;
    logic [1:0]       regdst_dec;
    logic             regWriteEn_dec;
    logic             memRead_dec;
    logic [W-1:0]     rdA_dec;
    logic [W-1:0]     rdB_dec;
    logic [W-1:0]     imm_dec;
    logic [W-1:0]     pc_dec;
    logic             flush;
    logic             ext_stall;
    logic [W-1:0]     instr_hazard;
    logic [1:0]       regdst_hazard;
    logic             regWriteEn;
    logic             memRead_ex;
    logic [W-1:0]     rdA_ex;
    logic [W-1:0]     rdB_ex;
    logic [W-1:0]     imm_ex;
    logic [W-1:0]     pc_ex;
    logic             valid_ex;
    logic             stall_if;
    logic             halted;
    logic [CNT_W-1:0] bubble_cnt;

    modport master (
        output instr_dec, valid_dec, regdst_dec, regWriteEn_dec, memRead_dec,
               rdA_dec, rdB_dec, imm_dec, pc_dec, flush, ext_stall,
        input  instr_hazard, regdst_hazard, regWriteEn, memRead_ex, rdA_ex, rdB_ex,
               imm_ex, pc_ex, valid_ex, stall_if, halted, bubble_cnt
    );

    modport slave (
        input  instr_dec, valid_dec, regdst_dec, regWriteEn_dec, memRead_dec,
               rdA_dec, rdB_dec, imm_dec, pc_dec, flush, ext_stall,
        output instr_hazard, regdst_hazard, regWriteEn, memRead_ex, rdA_ex, rdB_ex,
               imm_ex, pc_ex, valid_ex, stall_if, halted, bubble_cnt
    );
endinterface

// File: rtl/idex_pipe_reg_loaduse_det.sv
// idex_loaduse_det: flags a decode instruction that reads the register a load in EX
// has not yet produced (the one case forwarding cannot cover).
module idex_loaduse_det
    import idex_pipe_reg_pkg::*;
(
    input  logic [15:2] instr_ex,
    input  logic [1:0]  regdst_ex,
    input  logic        valid_ex,
    input  logic        memread_ex,
    input  logic        regwrite_ex,
    input  logic [15:5] instr_dec,
    input  logic        valid_dec,
    output logic        load_use
);
    logic [2:0] dst_ex;
    logic [4:0] op;

    assign dst_ex = dst_reg(instr_ex, regdst_ex);
    assign op = instr_dec[15:11];
    assign load_use = valid_ex & memread_ex & regwrite_ex & valid_dec &
                      ((rs_used(op) & (dst_ex == instr_dec[10:8])) |
                       (rt_used(op) & (dst_ex == instr_dec[7:5])));
endmodule

// File: rtl/idex_pipe_reg.sv
// idex_pipe_reg: ID/EX pipeline register with load-use bubble insertion, flush,
// external-stall hold, HALT freeze and a saturating bubble counter.
module idex_pipe_reg
    import idex_pipe_reg_pkg::*;
#(
    parameter int           W         = DATA_W,
    parameter logic [W-1:0] NOP_INSTR = NOP_ENC,
    parameter int           CNT_W     = 16
) (
    input logic clk,
    input logic rst,
    idex_pipe_reg_if.slave bus
);
    state_e state_q, state_d;
    logic [W-1:0] instr_q, rda_q, rdb_q, imm_q, pc_q;
    logic [1:0] regdst_q;
    logic regwrite_q, memread_q, valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic load_use, halt_det, hold, bubble, bump, stall;

    idex_loaduse_det u_det (
        .instr_ex   (instr_q[15:2]),
        .regdst_ex  (regdst_q),
        .valid_ex   (valid_q),
        .memread_ex (memread_q),
        .regwrite_ex(regwrite_q),
        .instr_dec  (bus.instr_dec[15:5]),
        .valid_dec  (bus.valid_dec),
        .load_use   (load_use)
    );

    assign halt_det = valid_q & (instr_q[15:11] == OP_HALT);

    // HALT freezes the pipe the same cycle it is seen in EX; halted follows a cycle later
    always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        bubble  = 1'b0;
        bump    = 1'b0;
        stall   = 1'b0;
        if (state_q == ST_HALT) begin
            hold  = 1'b1;
            stall = 1'b1;
        end else if (bus.flush) begin
            bubble  = 1'b1;
            state_d = ST_RUN;
        end else if (halt_det) begin
            hold    = 1'b1;
            stall   = 1'b1;
            state_d = ST_HALT;
        end else if (bus.ext_stall) begin
            hold  = 1'b1;
            stall = 1'b1;
        end else if (load_use) begin
            bubble  = 1'b1;
            bump    = 1'b1;
            stall   = 1'b1;
            state_d = ST_BUBBLE;
        end else begin
            bubble  = !bus.valid_dec;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            instr_q    <= NOP_INSTR;
            regdst_q   <= 2'b00;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            valid_q    <= 1'b0;
            rda_q      <= '0;
            rdb_q      <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (!hold) begin
                instr_q    <= bubble ? NOP_INSTR : bus.instr_dec;
                regdst_q   <= bubble ? 2'b00 : bus.regdst_dec;
                regwrite_q <= !bubble & bus.regWriteEn_dec;
                memread_q  <= !bubble & bus.memRead_dec;
                valid_q    <= !bubble;
                rda_q      <= bus.rdA_dec;
                rdb_q      <= bus.rdB_dec;
                imm_q      <= bus.imm_dec;
                pc_q       <= bus.pc_dec;
            end
            if (bump && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.instr_hazard  = instr_q;
    assign bus.regdst_hazard = regdst_q;
    assign bus.regWriteEn    = regwrite_q;
    assign bus.memRead_ex    = memread_q;
    assign bus.rdA_ex        = rda_q;
    assign bus.rdB_ex        = rdb_q;
    assign bus.imm_ex        = imm_q;
    assign bus.pc_ex         = pc_q;
    assign bus.valid_ex      = valid_q;
    assign bus.stall_if      = stall;
    assign bus.halted        = (state_q == ST_HALT);
    assign bus.bubble_cnt    = cnt_q;
endmodule

// File: tb/tb_idex_pipe_reg.sv
// tb_idex_pipe_reg: directed vector table for hazard detection plus hand-written
// sequences for flush, ext_stall, reset, HALT and counter saturation.
module tb_idex_pipe_reg;
    import idex_pipe_reg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    idex_pipe_reg_if #(.W(16), .CNT_W(16)) bus ();
    idex_pipe_reg_if #(.W(16), .CNT_W(4))  sbus ();

    idex_pipe_reg #(.W(16), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    idex_pipe_reg #(.W(16), .CNT_W(4))  sdut (.clk(clk), .rst(rst), .bus(sbus));

    localparam logic [15:0] LD_R3  = {OP_LD, 3'd1, 3'd3, 5'd0};
    localparam logic [15:0] ADD_RS3 = 16'hDB50;
    localparam logic [15:0] ADD_IND = 16'hD950;
    localparam logic [15:0] NOP_I  = 16'h0800;

    typedef struct {
        logic [15:0] ex_instr;
        logic [1:0]  ex_regdst;
        logic        ex_mr;
        logic [15:0] dec;
        logic        dec_valid;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[11];
    int checks = 0;
    int errors = 0;
    int cnt_m  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] instr, input logic v, input logic [1:0] rd,
                         input logic we, input logic mr, input logic [15:0] a);
        bus.instr_dec      = instr;
        bus.valid_dec      = v;
        bus.regdst_dec     = rd;
        bus.regWriteEn_dec = we;
        bus.memRead_dec    = mr;
        bus.rdA_dec        = a;
        bus.rdB_dec        = ~a;
        bus.imm_dec        = a + 16'd1;
        bus.pc_dec         = a + 16'd2;
    endtask

    task automatic sdrive(input logic [15:0] instr, input logic v, input logic mr);
        sbus.instr_dec      = instr;
        sbus.valid_dec      = v;
        sbus.regdst_dec     = 2'b01;
        sbus.regWriteEn_dec = 1'b1;
        sbus.memRead_dec    = mr;
        sbus.rdA_dec        = '0;
        sbus.rdB_dec        = '0;
        sbus.imm_dec        = '0;
        sbus.pc_dec         = '0;
    endtask

    initial begin
        vecs[0]  = '{LD_R3,   2'b01, 1'b1, ADD_RS3, 1'b1, 1'b1};
        vecs[1]  = '{LD_R3,   2'b01, 1'b1, ADD_IND, 1'b1, 1'b0};
        vecs[2]  = '{LD_R3,   2'b01, 1'b1, 16'hC305, 1'b1, 1'b0};
        vecs[3]  = '{LD_R3,   2'b01, 1'b1, 16'h8160, 1'b1, 1'b1};
        vecs[4]  = '{LD_R3,   2'b11, 1'b1, 16'hDF50, 1'b1, 1'b1};
        vecs[5]  = '{LD_R3,   2'b01, 1'b1, ADD_RS3, 1'b0, 1'b0};
        vecs[6]  = '{LD_R3,   2'b01, 1'b1, 16'hE170, 1'b1, 1'b1};
        vecs[7]  = '{LD_R3,   2'b01, 1'b1, 16'h2300, 1'b1, 1'b0};
        vecs[8]  = '{LD_R3,   2'b01, 1'b0, ADD_RS3, 1'b1, 1'b0};
        vecs[9]  = '{LD_R3,   2'b11, 1'b1, ADD_RS3, 1'b1, 1'b0};
        vecs[10] = '{16'hC305, 2'b00, 1'b1, ADD_RS3, 1'b1, 1'b1};

        bus.flush = 1'b0; bus.ext_stall = 1'b0;
        sbus.flush = 1'b0; sbus.ext_stall = 1'b0;
        drive(NOP_I, 1'b0, 2'b00, 1'b0, 1'b0, 16'h0);
        sdrive(NOP_I, 1'b0, 1'b0);
        tick;
        tick;
        chk("rst_instr", bus.instr_hazard, NOP_I);
        chk("rst_valid", bus.valid_ex, 0);
        chk("rst_cnt", bus.bubble_cnt, 0);
        chk("rst_stall", bus.stall_if, 0);
        chk("rst_halted", bus.halted, 0);
        rst = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].ex_instr, 1'b1, vecs[i].ex_regdst, 1'b1, vecs[i].ex_mr, 16'h00A0);
            tick;
            drive(vecs[i].dec, vecs[i].dec_valid, 2'b00, 1'b1, 1'b0, 16'h00B0);
            #1;
            chk($sformatf("vec%0d_stall", i), bus.stall_if, vecs[i].exp_stall);
            if (vecs[i].exp_stall) cnt_m++;
            tick;
            chk($sformatf("vec%0d_instr", i), bus.instr_hazard,
                (vecs[i].exp_stall || !vecs[i].dec_valid) ? NOP_I : vecs[i].dec);
            chk($sformatf("vec%0d_valid", i), bus.valid_ex, !vecs[i].exp_stall && vecs[i].dec_valid);
            chk($sformatf("vec%0d_cnt", i), bus.bubble_cnt, cnt_m);
        end

        // load-use: one bubble, then the consumer enters EX
        drive(LD_R3, 1'b1, 2'b01, 1'b1, 1'b1, 16'h0C00);
        tick;
        drive(ADD_RS3, 1'b1, 2'b00, 1'b1, 1'b0, 16'h1111);
        #1;
        chk("lu_stall", bus.stall_if, 1);
        cnt_m++;
        tick;
        chk("lu_bubble", bus.instr_hazard, NOP_I);
        chk("lu_bubble_we", bus.regWriteEn, 0);
        chk("lu_cnt", bus.bubble_cnt, cnt_m);
        chk("lu_release", bus.stall_if, 0);
        tick;
        chk("lu_add_instr", bus.instr_hazard, ADD_RS3);
        chk("lu_add_valid", bus.valid_ex, 1);
        chk("lu_add_rda", bus.rdA_ex, 16'h1111);
        chk("lu_add_pc", bus.pc_ex, 16'h1113);

        // flush beats load-use
        drive(LD_R3, 1'b1, 2'b01, 1'b1, 1'b1, 16'h0C00);
        tick;
        drive(ADD_RS3, 1'b1, 2'b00, 1'b1, 1'b0, 16'h1111);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", bus.stall_if, 0);
        tick;
        bus.flush = 1'b0;
        chk("fl_instr", bus.instr_hazard, NOP_I);
        chk("fl_valid", bus.valid_ex, 0);
        chk("fl_mr", bus.memRead_ex, 0);
        chk("fl_cnt", bus.bubble_cnt, cnt_m);

        // ext_stall freezes EX for three cycles
        drive(ADD_IND, 1'b1, 2'b00, 1'b1, 1'b0, 16'h2222);
        tick;
        drive(ADD_RS3, 1'b1, 2'b00, 1'b1, 1'b0, 16'h3333);
        bus.ext_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("es%0d_stall", k), bus.stall_if, 1);
            tick;
            chk($sformatf("es%0d_instr", k), bus.instr_hazard, ADD_IND);
            chk($sformatf("es%0d_rda", k), bus.rdA_ex, 16'h2222);
        end
        bus.ext_stall = 1'b0;
        tick;
        chk("es_resume", bus.instr_hazard, ADD_RS3);
        chk("es_resume_rda", bus.rdA_ex, 16'h3333);

        // asynchronous reset mid-stream
        drive(LD_R3, 1'b1, 2'b01, 1'b1, 1'b1, 16'h0C00);
        tick;
        drive(ADD_RS3, 1'b1, 2'b00, 1'b1, 1'b0, 16'h1111);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_instr", bus.instr_hazard, NOP_I);
        chk("mr_valid", bus.valid_ex, 0);
        chk("mr_cnt", bus.bubble_cnt, 0);
        chk("mr_stall", bus.stall_if, 0);
        @(negedge clk);
        rst = 1'b1;
        cnt_m = 0;

        // HALT freezes the pipe until reset
        drive(16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h4444);
        tick;
        chk("ht_enter_stall", bus.stall_if, 1);
        tick;
        chk("ht_halted", bus.halted, 1);
        drive(ADD_IND, 1'b1, 2'b00, 1'b1, 1'b0, 16'h5555);
        for (int k = 0; k < 10; k++) begin
            tick;
            chk($sformatf("ht%0d_instr", k), bus.instr_hazard, 16'h0000);
            chk($sformatf("ht%0d_stall", k), bus.stall_if, 1);
            chk($sformatf("ht%0d_halted", k), bus.halted, 1);
        end
        chk("ht_rda", bus.rdA_ex, 16'h4444);
        rst = 1'b0;
        #1;
        chk("ht_rst_halted", bus.halted, 0);
        chk("ht_rst_instr", bus.instr_hazard, NOP_I);
        chk("ht_rst_stall", bus.stall_if, 0);
        @(negedge clk);
        rst = 1'b1;

        // counter saturation on the narrow-counter instance
        for (int i = 0; i < 20; i++) begin
            sdrive(LD_R3, 1'b1, 1'b1);
            tick;
            sdrive(ADD_RS3, 1'b1, 1'b0);
            tick;
            if (i == 13) chk("sat_14", sbus.bubble_cnt, 14);
        end
        chk("sat_full", sbus.bubble_cnt, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
